// File: rtl/pipe_stage_reg.sv
// Stage register carrying a control bundle plus LANES data words; 1-cycle latency, no In->Out comb path.
// Backpressure: SKID=1 absorbs one extra entry behind a registered In_Ready; SKID=0 passes Out_Ready back combinationally.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int CTRL_W = 13,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Flush,
    input  logic                      In_Valid,
    output logic                      In_Ready,
    input  logic [CTRL_W-1:0]         In_Ctrl,
    input  logic [LANES*DATA_W-1:0]   In_Data,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    output logic [CTRL_W-1:0]         Out_Ctrl,
    output logic [LANES*DATA_W-1:0]   Out_Data,
    output logic [1:0]                Occupancy,
    output logic [CNT_W-1:0]          StallCount
);

    localparam int PW = LANES * DATA_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [PW-1:0]     data;
    } ent_t;

    // Encoding doubles as the entry count reported on Occupancy.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t           state;
    state_t           nxt;
    ent_t             m_q;
    ent_t             s_q;
    ent_t             in_ent;
    logic             in_fire;
    logic             out_fire;
    logic             m_load_in;
    logic             m_load_s;
    logic             s_load;
    logic [CNT_W-1:0] stall_q;

    assign in_ent     = '{ctrl: In_Ctrl, data: In_Data};
    assign Out_Valid  = (state != ST_EMPTY);
    assign Out_Ctrl   = Out_Valid ? m_q.ctrl : '0;
    assign Out_Data   = m_q.data;
    assign Occupancy  = state;
    assign StallCount = stall_q;
    assign in_fire    = In_Valid & In_Ready;
    assign out_fire   = Out_Valid & Out_Ready;

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;
            // Resets high so the first edge after reset release can already accept.
            always_ff @(posedge Clk or negedge Reset) begin
                if (!Reset) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (nxt != ST_SKID);
                end
            end
            assign In_Ready = rdy_q & Reset & ~Flush;
        end else begin : g_noskid
            assign In_Ready = (Out_Ready | ~Out_Valid) & Reset & ~Flush;
        end
    endgenerate

    always_comb begin
        nxt       = state;
        m_load_in = 1'b0;
        m_load_s  = 1'b0;
        s_load    = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    nxt       = ST_FULL;
                    m_load_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    m_load_in = 1'b1;
                end else if (in_fire) begin
                    nxt    = ST_SKID;
                    s_load = 1'b1;
                end else if (out_fire) begin
                    nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    nxt      = ST_FULL;
                    m_load_s = 1'b1;
                end
            end
            default: nxt = ST_EMPTY;
        endcase
        if (Flush) begin
            nxt       = ST_EMPTY;
            m_load_in = 1'b0;
            m_load_s  = 1'b0;
            s_load    = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_EMPTY;
            m_q   <= '0;
            s_q   <= '0;
        end else begin
            state <= nxt;
            if (m_load_in) begin
                m_q <= in_ent;
            end else if (m_load_s) begin
                m_q <= s_q;
            end
            if (s_load) begin
                s_q <= in_ent;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_q <= '0;
        end else if (Out_Valid && !Out_Ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table, hand sequences, and a depth-limited FIFO reference model.
module tb_pipe_stage_reg;

    localparam int CW = 13;
    localparam int PW = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          fl[2], iv[2], irdy[2], ov[2], ordy[2];
    logic [CW-1:0] ictrl[2], octrl[2];
    logic [PW-1:0] idata[2], odata[2];
    logic [1:0]    occ[2];
    logic [15:0]   stc[2];

    logic          irdy4, ov4;
    logic [CW-1:0] octrl4;
    logic [PW-1:0] odata4;
    logic [1:0]    occ4;
    logic [3:0]    stc4;

    pipe_stage_reg #(.DATA_W(32), .LANES(4), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_s1 (
        .Clk(clk), .Reset(rst_n), .Flush(fl[0]), .In_Valid(iv[0]), .In_Ready(irdy[0]),
        .In_Ctrl(ictrl[0]), .In_Data(idata[0]), .Out_Valid(ov[0]), .Out_Ready(ordy[0]),
        .Out_Ctrl(octrl[0]), .Out_Data(odata[0]), .Occupancy(occ[0]), .StallCount(stc[0]));

    pipe_stage_reg #(.DATA_W(32), .LANES(4), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_s0 (
        .Clk(clk), .Reset(rst_n), .Flush(fl[1]), .In_Valid(iv[1]), .In_Ready(irdy[1]),
        .In_Ctrl(ictrl[1]), .In_Data(idata[1]), .Out_Valid(ov[1]), .Out_Ready(ordy[1]),
        .Out_Ctrl(octrl[1]), .Out_Data(odata[1]), .Occupancy(occ[1]), .StallCount(stc[1]));

    pipe_stage_reg #(.DATA_W(32), .LANES(4), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c4 (
        .Clk(clk), .Reset(rst_n), .Flush(fl[0]), .In_Valid(iv[0]), .In_Ready(irdy4),
        .In_Ctrl(ictrl[0]), .In_Data(idata[0]), .Out_Valid(ov4), .Out_Ready(ordy[0]),
        .Out_Ctrl(octrl4), .Out_Data(odata4), .Occupancy(occ4), .StallCount(stc4));

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [PW-1:0] d;
    } ent_t;

    // Reference: harness 0 is a 2-deep FIFO, harness 1 a 1-deep FIFO with pass-through ready.
    ent_t mq[2][2];
    int   mn[2];
    int   mst[2];
    int   mst4;
    int   ndeliv;

    localparam logic [PW-1:0] DA = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [PW-1:0] DB = {4{32'h0000_000B}};
    localparam logic [PW-1:0] DC = {4{32'h0000_000C}};
    localparam logic [PW-1:0] DD = {4{32'h0000_000D}};
    localparam logic [PW-1:0] DE = {4{32'h0000_000E}};
    localparam logic [PW-1:0] DF = {4{32'h0000_000F}};

    typedef struct {
        logic          fl;
        logic          iv;
        logic [CW-1:0] c;
        logic [PW-1:0] d;
        logic          ordy;
        logic          ev;
        logic [CW-1:0] ec;
        logic [PW-1:0] ed;
        logic [1:0]    eo;
        logic          er;
        logic [15:0]   es;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        for (int h = 0; h < 2; h++) begin
            fl[h] = 1'b0; iv[h] = 1'b0; ordy[h] = 1'b0;
            ictrl[h] = '0; idata[h] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        for (int h = 0; h < 2; h++) begin
            chk($sformatf("h%0d rst out_valid", h), 128'(ov[h]), 128'(0));
            chk($sformatf("h%0d rst out_ctrl", h), 128'(octrl[h]), 128'(0));
            chk($sformatf("h%0d rst out_data", h), odata[h], 128'(0));
            chk($sformatf("h%0d rst occupancy", h), 128'(occ[h]), 128'(0));
            chk($sformatf("h%0d rst stall", h), 128'(stc[h]), 128'(0));
            chk($sformatf("h%0d rst in_ready", h), 128'(irdy[h]), 128'(0));
        end
        rst_n = 1'b1;
        for (int h = 0; h < 2; h++) begin
            mn[h] = 0; mst[h] = 0;
        end
        mst4 = 0;
        ndeliv = 0;
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic mcycle(input int h, output logic acc);
        logic r, inf, outf;
        #1;
        if (fl[h]) r = 1'b0;
        else if (h == 0) r = (mn[h] < 2);
        else r = (mn[h] == 0) || ordy[h];
        chk($sformatf("h%0d in_ready", h), 128'(irdy[h]), 128'(r));
        chk($sformatf("h%0d out_valid", h), 128'(ov[h]), 128'(mn[h] > 0));
        chk($sformatf("h%0d out_ctrl", h), 128'(octrl[h]), (mn[h] > 0) ? 128'(mq[h][0].c) : 128'(0));
        if (mn[h] > 0) chk($sformatf("h%0d out_data", h), odata[h], mq[h][0].d);
        chk($sformatf("h%0d occupancy", h), 128'(occ[h]), 128'(mn[h]));
        chk($sformatf("h%0d stall", h), 128'(stc[h]), 128'(mst[h]));
        if (h == 0) chk("stall4", 128'(stc4), 128'(mst4));
        inf  = iv[h] && r;
        outf = (mn[h] > 0) && ordy[h];
        if (h == 0 && ov[0] && ordy[0]) ndeliv++;
        @(posedge clk);
        if (mn[h] > 0 && !ordy[h]) begin
            if (mst[h] < 65535) mst[h]++;
            if (h == 0 && mst4 < 15) mst4++;
        end
        if (fl[h]) begin
            mn[h] = 0;
        end else begin
            if (outf) begin
                mq[h][0] = mq[h][1];
                mn[h]--;
            end
            if (inf) begin
                mq[h][mn[h]] = '{c: ictrl[h], d: idata[h]};
                mn[h]++;
            end
        end
        acc = inf;
        #1;
    endtask

    task automatic rnd(input int h, input int n, input int pf);
        logic pend, acc;
        pend = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!pend) begin
                iv[h]    = ($urandom_range(0, 3) != 0);
                ictrl[h] = 13'($urandom);
                idata[h] = {$urandom, $urandom, $urandom, $urandom};
            end
            ordy[h] = ($urandom_range(0, 2) != 0);
            fl[h]   = ($urandom_range(0, pf - 1) == 0);
            mcycle(h, acc);
            pend = iv[h] && !acc;
        end
        fl[h] = 1'b0;
        iv[h] = 1'b0;
    endtask

    initial begin
        logic acc;
        logic pend;

        tbl[0] = '{1'b0, 1'b1, 13'h1001, DA, 1'b1, 1'b1, 13'h1001, DA, 2'd1, 1'b1, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 13'h0002, DB, 1'b0, 1'b1, 13'h1001, DA, 2'd2, 1'b0, 16'd1};
        tbl[2] = '{1'b0, 1'b1, 13'h0003, DC, 1'b0, 1'b1, 13'h1001, DA, 2'd2, 1'b0, 16'd2};
        tbl[3] = '{1'b0, 1'b0, 13'h0000, '0, 1'b1, 1'b1, 13'h0002, DB, 2'd1, 1'b1, 16'd2};
        tbl[4] = '{1'b0, 1'b0, 13'h0000, '0, 1'b1, 1'b0, 13'h0000, '0, 2'd0, 1'b1, 16'd2};
        tbl[5] = '{1'b0, 1'b1, 13'h0004, DD, 1'b0, 1'b1, 13'h0004, DD, 2'd1, 1'b1, 16'd2};
        tbl[6] = '{1'b0, 1'b1, 13'h0005, DE, 1'b0, 1'b1, 13'h0004, DD, 2'd2, 1'b0, 16'd3};
        tbl[7] = '{1'b1, 1'b1, 13'h0006, DF, 1'b0, 1'b0, 13'h0000, '0, 2'd0, 1'b0, 16'd4};
        tbl[8] = '{1'b0, 1'b0, 13'h0000, '0, 1'b1, 1'b0, 13'h0000, '0, 2'd0, 1'b1, 16'd4};

        #2;
        do_reset();

        // Directed table: first entry, skid fill/drain order, flush with full skid.
        for (int i = 0; i < 9; i++) begin
            fl[0] = tbl[i].fl; iv[0] = tbl[i].iv; ictrl[0] = tbl[i].c;
            idata[0] = tbl[i].d; ordy[0] = tbl[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d out_valid", i), 128'(ov[0]), 128'(tbl[i].ev));
            chk($sformatf("tbl%0d out_ctrl", i), 128'(octrl[0]), 128'(tbl[i].ec));
            if (tbl[i].ev) chk($sformatf("tbl%0d out_data", i), odata[0], tbl[i].ed);
            chk($sformatf("tbl%0d occupancy", i), 128'(occ[0]), 128'(tbl[i].eo));
            chk($sformatf("tbl%0d in_ready", i), 128'(irdy[0]), 128'(tbl[i].er));
            chk($sformatf("tbl%0d stall", i), 128'(stc[0]), 128'(tbl[i].es));
            chk($sformatf("tbl%0d stall4", i), 128'(stc4), 128'(tbl[i].es));
        end

        // Stall counting and saturation of the 4-bit counter.
        do_reset();
        iv[0] = 1'b1; ictrl[0] = 13'h1001; idata[0] = DA; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stall5", 128'(stc[0]), 128'(5));
        chk("stall5 c4", 128'(stc4), 128'(5));
        repeat (15) @(posedge clk);
        #1;
        chk("stall20", 128'(stc[0]), 128'(20));
        chk("stall20 c4 sat", 128'(stc4), 128'(15));
        repeat (3) @(posedge clk);
        #1;
        chk("stall23", 128'(stc[0]), 128'(23));
        chk("stall23 c4 held", 128'(stc4), 128'(15));
        fl[0] = 1'b1;
        @(posedge clk); #1;
        fl[0] = 1'b0;
        chk("flush out_valid", 128'(ov[0]), 128'(0));
        chk("stall after flush", 128'(stc[0]), 128'(24));
        @(posedge clk); #1;
        chk("stall idle", 128'(stc[0]), 128'(24));
        chk("stall idle c4", 128'(stc4), 128'(15));

        // Asynchronous reset between edges while FULL.
        do_reset();
        iv[0] = 1'b1; ictrl[0] = 13'h0002; idata[0] = DB; ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        chk("pre-arst out_valid", 128'(ov[0]), 128'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 128'(ov[0]), 128'(0));
        chk("arst out_data", odata[0], 128'(0));
        chk("arst out_ctrl", 128'(octrl[0]), 128'(0));
        chk("arst occupancy", 128'(occ[0]), 128'(0));
        chk("arst in_ready", 128'(irdy[0]), 128'(0));
        iv[0] = 1'b1; ictrl[0] = 13'h0003; idata[0] = DC; ordy[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("arst held in_ready", 128'(irdy[0]), 128'(0));
        chk("arst held out_valid", 128'(ov[0]), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("arst release in_ready", 128'(irdy[0]), 128'(1));
        @(posedge clk); #1;
        chk("arst first accept valid", 128'(ov[0]), 128'(1));
        chk("arst first accept data", odata[0], DC);
        iv[0] = 1'b0;

        // Back-to-back stream of 100 entries.
        do_reset();
        ordy[0] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            iv[0] = 1'b1; ictrl[0] = 13'(k); idata[0] = {4{32'(k)}};
            mcycle(0, acc);
        end
        iv[0] = 1'b0;
        repeat (3) mcycle(0, acc);
        chk("stream delivered", 128'(ndeliv), 128'(100));

        do_reset();
        rnd(0, 400, 25);

        // SKID=0: Out_Ready alternating under continuous input.
        do_reset();
        pend = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!pend) begin
                iv[1] = 1'b1; ictrl[1] = 13'(i + 16); idata[1] = {4{32'(i + 500)}};
            end
            ordy[1] = (i % 2 == 0);
            mcycle(1, acc);
            pend = !acc;
        end
        iv[1] = 1'b0;
        rnd(1, 400, 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
